// File: rtl/disp_arbiter.sv
// ============================================================================
// Module      : disp_arbiter
// Description : Round-robin arbiter granting one of four sources ownership
//               of a decimal display for a fixed dwell, with a blank gap
//               cycle between different owners.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module disp_arbiter #(
    parameter int unsigned DWELL = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    input  logic [7:0] val3,
    input  logic       hold,
    output logic [3:0] grant,
    output logic [7:0] disp_value,
    output logic       disp_enable,
    output logic       dwell_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] C_DWELL_LAST = 16'(DWELL - 1);

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  disp_value_q, disp_value_d;
    logic        disp_enable_q, disp_enable_d;
    logic        dwell_done_q, dwell_done_d;

    logic [7:0]  w_vals [4];
    logic        w_win_found;
    logic [1:0]  w_win_idx;

    assign w_vals[0] = val0;
    assign w_vals[1] = val1;
    assign w_vals[2] = val2;
    assign w_vals[3] = val3;

    // Search starts just after the previous owner; the owner itself is seen last.
    always_comb begin
        logic [1:0] idx;
        w_win_found = 1'b0;
        w_win_idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!w_win_found && req[idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        disp_value_d  = disp_value_q;
        disp_enable_d = disp_enable_q;
        dwell_done_d  = 1'b0;

        case (state_q)
            SHOW: begin
                disp_value_d = w_vals[last_q];
                if (!req[last_q]) begin
                    state_d       = w_win_found ? GAP : IDLE;
                    grant_d       = 4'b0000;
                    disp_enable_d = 1'b0;
                    cnt_d         = 16'd0;
                end else if (cnt_q == C_DWELL_LAST) begin
                    // hold parks the counter at the last dwell cycle
                    if (!hold) begin
                        dwell_done_d = 1'b1;
                        cnt_d        = 16'd0;
                        if (w_win_idx != last_q) begin
                            state_d       = GAP;
                            grant_d       = 4'b0000;
                            disp_enable_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (w_win_found) begin
                    state_d       = SHOW;
                    grant_d       = 4'b0001 << w_win_idx;
                    last_d        = w_win_idx;
                    cnt_d         = 16'd0;
                    disp_enable_d = 1'b1;
                    disp_value_d  = w_vals[w_win_idx];
                end else begin
                    state_d       = IDLE;
                    grant_d       = 4'b0000;
                    disp_enable_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 2'd3;
            cnt_q         <= 16'd0;
            grant_q       <= 4'b0000;
            disp_value_q  <= 8'd0;
            disp_enable_q <= 1'b0;
            dwell_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            disp_value_q  <= disp_value_d;
            disp_enable_q <= disp_enable_d;
            dwell_done_q  <= dwell_done_d;
        end
    end

    assign grant       = grant_q;
    assign disp_value  = disp_value_q;
    assign disp_enable = disp_enable_q;
    assign dwell_done  = dwell_done_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_arbiter.sv
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Scoreboard bench for disp_arbiter with DWELL=4.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_disp_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] val0 = 8'd0;
    logic [7:0] val1 = 8'd0;
    logic [7:0] val2 = 8'd0;
    logic [7:0] val3 = 8'd0;
    logic       hold = 1'b0;
    logic [3:0] grant;
    logic [7:0] disp_value;
    logic       disp_enable;
    logic       dwell_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] g;
        logic       dd;
        logic [7:0] dv;
    } exp_t;

    exp_t exp_q[$];

    disp_arbiter #(.DWELL(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .val0       (val0),
        .val1       (val1),
        .val2       (val2),
        .val3       (val3),
        .hold       (hold),
        .grant      (grant),
        .disp_value (disp_value),
        .disp_enable(disp_enable),
        .dwell_done (dwell_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", {28'd0, grant}, {28'd0, e.g});
            check("disp_enable", {31'd0, disp_enable}, {31'd0, |e.g});
            check("dwell_done", {31'd0, dwell_done}, {31'd0, e.dd});
            check("disp_value", {24'd0, disp_value}, {24'd0, e.dv});
            check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            check("enable_eq_or_grant", {31'd0, disp_enable}, {31'd0, |grant});
        end
    end

    // Apply inputs, take one edge, queue what the outputs must show after it.
    task automatic cyc(input logic rst, input logic [3:0] r, input logic h,
                       input logic [3:0] g, input logic dd, input logic [7:0] dv);
        reset = rst;
        req   = r;
        hold  = h;
        @(posedge clk);
        #1;
        exp_q.push_back('{g: g, dd: dd, dv: dv});
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        cyc(1, 4'b0000, 0, 4'b0000, 0, 8'h00);

        // Single requester, val0 = -42: no gap, dwell_done every 4 cycles
        val0 = 8'hD6;
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'hD6);
        for (int i = 1; i <= 8; i++)
            cyc(0, 4'b0001, 0, 4'b0001, (i % 4 == 0), 8'hD6);
        cyc(1, 4'b0001, 0, 4'b0000, 0, 8'h00);

        // Two requesters alternate with a one-cycle gap
        val0 = 8'h11; val1 = 8'h44; val2 = 8'h22; val3 = 8'h33;
        cyc(0, 4'b0101, 0, 4'b0001, 0, 8'h11);
        cyc(0, 4'b0101, 0, 4'b0001, 0, 8'h11);
        cyc(0, 4'b0101, 0, 4'b0001, 0, 8'h11);
        cyc(0, 4'b0101, 0, 4'b0001, 0, 8'h11);
        cyc(0, 4'b0101, 0, 4'b0000, 1, 8'h11);
        cyc(0, 4'b0101, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b0101, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b0101, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b0101, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b0101, 0, 4'b0000, 1, 8'h22);
        cyc(0, 4'b0101, 0, 4'b0001, 0, 8'h11);
        cyc(1, 4'b0000, 0, 4'b0000, 0, 8'h00);

        // Owner 2 drops its request in its second cycle
        cyc(0, 4'b0100, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b0100, 0, 4'b0100, 0, 8'h22);
        cyc(0, 4'b1001, 0, 4'b0000, 0, 8'h22);
        cyc(0, 4'b1001, 0, 4'b1000, 0, 8'h33);
        cyc(0, 4'b1001, 0, 4'b1000, 0, 8'h33);
        cyc(0, 4'b1001, 0, 4'b1000, 0, 8'h33);
        cyc(0, 4'b1001, 0, 4'b1000, 0, 8'h33);
        cyc(0, 4'b1001, 0, 4'b0000, 1, 8'h33);
        cyc(0, 4'b1001, 0, 4'b0001, 0, 8'h11);
        cyc(1, 4'b0000, 0, 4'b0000, 0, 8'h00);

        // hold freezes rotation at dwell expiry
        cyc(0, 4'b0011, 1, 4'b0001, 0, 8'h11);
        for (int i = 0; i < 9; i++)
            cyc(0, 4'b0011, 1, 4'b0001, 0, 8'h11);
        cyc(0, 4'b0011, 0, 4'b0000, 1, 8'h11);
        cyc(0, 4'b0011, 0, 4'b0010, 0, 8'h44);
        cyc(1, 4'b0000, 0, 4'b0000, 0, 8'h00);

        // Reset mid-SHOW, then all four requesting
        val1 = 8'h7F;
        cyc(0, 4'b0010, 0, 4'b0010, 0, 8'h7F);
        cyc(0, 4'b0010, 0, 4'b0010, 0, 8'h7F);
        cyc(1, 4'b0010, 0, 4'b0000, 0, 8'h00);
        cyc(0, 4'b1111, 0, 4'b0001, 0, 8'h11);
        cyc(1, 4'b1111, 0, 4'b0000, 0, 8'h00);

        // disp_value tracks val0 with one cycle of latency
        val0 = 8'h05;
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'h05);
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'h05);
        val0 = 8'h80;
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'h80);
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'h80);
        cyc(0, 4'b0001, 0, 4'b0001, 1, 8'h80);
        cyc(0, 4'b0001, 0, 4'b0001, 0, 8'h80);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The module SHALL have parameter DWELL, default 8, giving the number of clock cycles one requester owns the display per grant (legal range 2..2^16-1).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, which is synchronous and active-high.
REQ-004 The module SHALL have port req, input, 4 bits, one request line per source, index 0..3.
REQ-005 The module SHALL have ports val0, val1, val2 and val3, each input, 8 bits, signed two's-complement value of the matching source.
REQ-006 The module SHALL have port hold, input, 1 bit; while high it freezes rotation at dwell expiry.
REQ-007 The module SHALL have port grant, output, 4 bits, one-hot owner of the display, or all-zero.
REQ-008 The module SHALL have port disp_value, output, 8 bits, signed value for the decimal display path.
REQ-009 The module SHALL have port disp_enable, output, 1 bit, display enable; low blanks all digits.
REQ-010 The module SHALL have port dwell_done, output, 1 bit, a one-cycle pulse at each dwell expiry.

Function
REQ-011 The module SHALL implement states IDLE, SHOW and GAP, with all outputs registered.
REQ-012 Arbitration SHALL be round-robin from pointer last: search (last+1) mod 4 upward with wrap; last itself is checked last.
REQ-013 In IDLE with req != 0, the next edge SHALL enter SHOW, set grant to the winner, set last to the winner, clear the dwell counter and set disp_enable to 1.
REQ-014 In SHOW, disp_value SHALL load the granted source's val every cycle, giving 1-cycle latency from val to disp_value.
REQ-015 In SHOW, the dwell counter SHALL increment each cycle; dwell_done SHALL pulse in the cycle the counter equals DWELL-1 and hold is 0.
REQ-016 At expiry with hold=0, if the winner equals the current owner, the module SHALL stay in SHOW, clear the counter and keep grant unchanged with no blank cycle.
REQ-017 At expiry with hold=0, if a different winner exists, the module SHALL enter GAP; if req=0 it SHALL enter IDLE.
REQ-018 While hold=1 and the counter is at DWELL-1, the counter SHALL hold, no dwell_done SHALL fire and the owner SHALL be retained.
REQ-019 If the owner's req falls while in SHOW, the next edge SHALL enter GAP (or IDLE if req=0), regardless of the counter or hold.
REQ-020 GAP SHALL last exactly one cycle with grant=0, disp_enable=0 and disp_value held; it SHALL then re-arbitrate as IDLE does, entering SHOW or, if req=0, IDLE.
REQ-021 In IDLE, grant SHALL be 0, disp_enable SHALL be 0 and disp_value SHALL hold its last value.
REQ-022 The counter width SHALL be 16 bits; the counter SHALL never wrap past DWELL-1.
REQ-023 grant SHALL never have more than one bit set, and disp_enable SHALL equal |grant in every cycle.

Reset
REQ-024 When reset=1 at an edge, the module SHALL set state to IDLE, grant=0, disp_enable=0, disp_value=0, dwell_done=0, counter=0 and last=3, so that source 0 has first priority.
REQ-025 reset SHALL override all other inputs, including mid-SHOW and mid-GAP; the first grant can occur on the edge after reset deasserts.

Verification (DWELL=4)
REQ-026 Reset then req=0001, val0=-42: the bench SHALL check that one edge later grant=0001, disp_enable=1 and disp_value=0xD6 (-42), and that dwell_done pulses every 4 cycles with no GAP.
REQ-027 req=0101 held constant: the bench SHALL check the sequence grant 0001 for 4 cycles, 0000 for 1 cycle, 0100 for 4 cycles, 0000 for 1 cycle, then back to 0001.
REQ-028 Owner 0100 drops req in its 2nd SHOW cycle with req=1001: the bench SHALL check that GAP follows next cycle, then grant=1000 (round-robin after 2), then 0001.
REQ-029 hold=1 with req=0011 and owner 0001: the bench SHALL check that grant stays 0001 and dwell_done stays 0 for 10 cycles; after hold falls, dwell_done pulses once, then GAP, then grant=0010.
REQ-030 reset asserted in SHOW with val1=127: the bench SHALL check that on the next edge all outputs are 0 and state is IDLE; with req=1111 after release, grant=0001.
REQ-031 val0 changing 5 -> -128 mid-SHOW: the bench SHALL check that disp_value follows one cycle later (0x80), and the bench SHALL check that one-hot grant and disp_enable=|grant are asserted every cycle.
